// File: rtl/matmul_pkg.sv
// Shared encodings and default widths for the 2x2 multiplier datapath.
// Used by the operand sequencer and by the result serializer.
package matmul_pkg;
   localparam int DW_DEF = 8;
   localparam int RW_DEF = 2*DW_DEF + 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_SEND = 2'b01,
      ST_DONE = 2'b10
   } ser_state_t;

   localparam logic [1:0] IDX_C00  = 2'd0;
   localparam logic [1:0] IDX_C01  = 2'd1;
   localparam logic [1:0] IDX_C10  = 2'd2;
   localparam logic [1:0] IDX_C11  = 2'd3;
   localparam logic [1:0] IDX_LAST = IDX_C11;
endpackage

// File: rtl/serializer_idx_counter.sv
// 2-bit modulo-4 element index for the result serializer.
// Clear wins over increment; nothing moves while ce is low.
module serializer_idx_counter
   import matmul_pkg::*;
(
   input  logic       clk,
   input  logic       mr,
   input  logic       ce,
   input  logic       clr,
   input  logic       inc,
   output logic [1:0] idx
);
   logic [1:0] r_idx;

   always_ff @(posedge clk or negedge mr) begin
      if (!mr) begin
         r_idx <= IDX_C00;
      end else if (ce) begin
         if (clr)
            r_idx <= IDX_C00;
         else if (inc)
            r_idx <= r_idx + 2'd1;
      end
   end

   assign idx = r_idx;
endmodule

// File: rtl/matrix_result_serializer.sv
// Captures C00..C11 in one cycle and streams them row-major over valid/ready.
//
// state | meaning
// IDLE  | waiting for load; captures c00..c11 when load=1
// SEND  | presenting elem[idx]; advances on each accepted transfer
// DONE  | one-cycle done pulse after C11 is accepted, then IDLE
module matrix_result_serializer
   import matmul_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int RW = 2*DW + 1
) (
   input  logic          clk,
   input  logic          mr,
   input  logic          ce,
   input  logic          load,
   input  logic [RW-1:0] c00,
   input  logic [RW-1:0] c01,
   input  logic [RW-1:0] c10,
   input  logic [RW-1:0] c11,
   input  logic          out_ready,
   output logic          out_valid,
   output logic [RW-1:0] out_data,
   output logic [1:0]    out_idx,
   output logic          out_last,
   output logic          busy,
   output logic          done
);
   ser_state_t    r_state;
   ser_state_t    w_state_nxt;
   logic [RW-1:0] r_elem [4];
   logic [RW-1:0] r_out_data;
   logic [1:0]    w_idx;
   logic [1:0]    w_idx_nxt;
   logic          w_capture;
   logic          w_xfer;

   always_ff @(posedge clk or negedge mr) begin
      if (!mr)
         r_state <= ST_IDLE;
      else if (ce)
         r_state <= w_state_nxt;
   end

   // out_ready only steers the next-state/transfer strobe, never out_data directly.
   always_comb begin
      w_state_nxt = r_state;
      w_capture   = 1'b0;
      w_xfer      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (load) begin
               w_capture   = 1'b1;
               w_state_nxt = ST_SEND;
            end
         end
         ST_SEND: begin
            if (out_ready) begin
               w_xfer = 1'b1;
               if (w_idx == IDX_LAST)
                  w_state_nxt = ST_DONE;
            end
         end
         ST_DONE:  w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   serializer_idx_counter u_idx_counter (
      .clk (clk),
      .mr  (mr),
      .ce  (ce),
      .clr (w_capture),
      .inc (w_xfer),
      .idx (w_idx)
   );

   assign w_idx_nxt = w_idx + 2'd1;

   always_ff @(posedge clk or negedge mr) begin
      if (!mr) begin
         for (int k = 0; k < 4; k++)
            r_elem[k] <= '0;
      end else if (ce && w_capture) begin
         r_elem[0] <= c00;
         r_elem[1] <= c01;
         r_elem[2] <= c10;
         r_elem[3] <= c11;
      end
   end

   // Preload the following element so out_data stays a plain register.
   always_ff @(posedge clk or negedge mr) begin
      if (!mr) begin
         r_out_data <= '0;
      end else if (ce) begin
         if (w_capture)
            r_out_data <= c00;
         else if (w_xfer)
            r_out_data <= (w_idx == IDX_LAST) ? '0 : r_elem[w_idx_nxt];
      end
   end

   assign out_valid = (r_state == ST_SEND);
   assign out_data  = r_out_data;
   assign out_idx   = w_idx;
   assign out_last  = out_valid && (w_idx == IDX_LAST);
   assign busy      = out_valid;
   assign done      = (r_state == ST_DONE);
endmodule

// File: tb/tb_matrix_result_serializer.sv
// Directed bench for matrix_result_serializer: stream order, backpressure,
// clock enable, load-while-busy, back-to-back timing and async reset.
module tb_matrix_result_serializer;
   localparam int RW = 17;

   logic          clk = 1'b0;
   logic          mr;
   logic          ce;
   logic          load;
   logic [RW-1:0] c00, c01, c10, c11;
   logic          out_ready;
   logic          out_valid;
   logic [RW-1:0] out_data;
   logic [1:0]    out_idx;
   logic          out_last;
   logic          busy;
   logic          done;

   int n_checks = 0;
   int n_errors = 0;

   matrix_result_serializer #(.DW(8), .RW(RW)) dut (
      .clk       (clk),
      .mr        (mr),
      .ce        (ce),
      .load      (load),
      .c00       (c00),
      .c01       (c01),
      .c10       (c10),
      .c11       (c11),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic v, input logic [RW-1:0] d,
                          input logic [1:0] i, input logic l, input logic b, input logic dn);
      chk({tag, ".valid"}, 32'(out_valid), 32'(v));
      chk({tag, ".data"},  32'(out_data),  32'(d));
      chk({tag, ".idx"},   32'(out_idx),   32'(i));
      chk({tag, ".last"},  32'(out_last),  32'(l));
      chk({tag, ".busy"},  32'(busy),      32'(b));
      chk({tag, ".done"},  32'(done),      32'(dn));
   endtask

   task automatic set_c(input logic [RW-1:0] a, input logic [RW-1:0] b,
                        input logic [RW-1:0] c, input logic [RW-1:0] d);
      c00 = a; c01 = b; c10 = c; c11 = d;
   endtask

   logic [RW-1:0] exp_d [4];

   initial begin
      mr = 1'b0; ce = 1'b1; load = 1'b0; out_ready = 1'b1;
      set_c('0, '0, '0, '0);
      tick(); tick();
      chk_out("reset", 1'b0, '0, 2'd0, 1'b0, 1'b0, 1'b0);
      mr = 1'b1;
      tick();
      chk_out("idle_after_reset", 1'b0, '0, 2'd0, 1'b0, 1'b0, 1'b0);

      // Basic stream with out_ready held high
      set_c(17'd10, 17'd20, 17'd30, 17'd40);
      exp_d[0] = 17'd10; exp_d[1] = 17'd20; exp_d[2] = 17'd30; exp_d[3] = 17'd40;
      load = 1'b1;
      tick();
      load = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk_out($sformatf("basic%0d", k), 1'b1, exp_d[k], 2'(k), (k == 3), 1'b1, 1'b0);
         tick();
      end
      chk_out("basic_done", 1'b0, '0, 2'd0, 1'b0, 1'b0, 1'b1);
      tick();
      chk_out("basic_idle", 1'b0, '0, 2'd0, 1'b0, 1'b0, 1'b0);

      // Backpressure at idx=1 plus a load attempt while busy
      load = 1'b1;
      tick();
      load = 1'b0;
      chk_out("bp0", 1'b1, 17'd10, 2'd0, 1'b0, 1'b1, 1'b0);
      tick();
      out_ready = 1'b0;
      set_c(17'h1FFFF, 17'd21, 17'd31, 17'd41);
      load = 1'b1;
      for (int k = 0; k < 3; k++) begin
         chk_out($sformatf("bp_hold%0d", k), 1'b1, 17'd20, 2'd1, 1'b0, 1'b1, 1'b0);
         tick();
      end
      load = 1'b0;
      chk_out("bp_hold3", 1'b1, 17'd20, 2'd1, 1'b0, 1'b1, 1'b0);
      out_ready = 1'b1;
      tick();
      chk_out("bp2", 1'b1, 17'd30, 2'd2, 1'b0, 1'b1, 1'b0);
      tick();
      chk_out("bp3", 1'b1, 17'd40, 2'd3, 1'b1, 1'b1, 1'b0);
      tick();
      chk_out("bp_done", 1'b0, '0, 2'd0, 1'b0, 1'b0, 1'b1);
      tick();

      // New values only captured by a load after DONE; ce freeze at idx=2
      load = 1'b1;
      tick();
      load = 1'b0;
      chk_out("ce0", 1'b1, 17'h1FFFF, 2'd0, 1'b0, 1'b1, 1'b0);
      tick();
      chk_out("ce1", 1'b1, 17'd21, 2'd1, 1'b0, 1'b1, 1'b0);
      tick();
      ce = 1'b0;
      for (int k = 0; k < 2; k++) begin
         chk_out($sformatf("ce_frz%0d", k), 1'b1, 17'd31, 2'd2, 1'b0, 1'b1, 1'b0);
         tick();
      end
      chk_out("ce_frz2", 1'b1, 17'd31, 2'd2, 1'b0, 1'b1, 1'b0);
      ce = 1'b1;
      tick();
      chk_out("ce3", 1'b1, 17'd41, 2'd3, 1'b1, 1'b1, 1'b0);
      tick();
      chk_out("ce_done", 1'b0, '0, 2'd0, 1'b0, 1'b0, 1'b1);
      tick();
      ce = 1'b0;
      load = 1'b1;
      tick();
      load = 1'b0;
      ce = 1'b1;
      chk_out("ce_idle_load", 1'b0, '0, 2'd0, 1'b0, 1'b0, 1'b0);
      tick();
      chk_out("ce_idle_after", 1'b0, '0, 2'd0, 1'b0, 1'b0, 1'b0);

      // Full-width back-to-back: second load accepted 6 cycles after the first
      set_c(17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 17'h1FFFF);
      load = 1'b1;
      tick();
      load = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk_out($sformatf("max%0d", k), 1'b1, 17'h1FFFF, 2'(k), (k == 3), 1'b1, 1'b0);
         tick();
      end
      set_c(17'h15555, 17'h0AAAA, 17'h1FFFF, 17'h10001);
      load = 1'b1;
      chk_out("max_done", 1'b0, '0, 2'd0, 1'b0, 1'b0, 1'b1);
      tick();
      chk_out("b2b_idle", 1'b0, '0, 2'd0, 1'b0, 1'b0, 1'b0);
      tick();
      load = 1'b0;
      exp_d[0] = 17'h15555; exp_d[1] = 17'h0AAAA; exp_d[2] = 17'h1FFFF; exp_d[3] = 17'h10001;
      for (int k = 0; k < 4; k++) begin
         chk_out($sformatf("b2b%0d", k), 1'b1, exp_d[k], 2'(k), (k == 3), 1'b1, 1'b0);
         tick();
      end
      chk_out("b2b_done", 1'b0, '0, 2'd0, 1'b0, 1'b0, 1'b1);
      tick();

      // Asynchronous reset mid-SEND at idx=2
      set_c(17'd10, 17'd20, 17'd30, 17'd40);
      load = 1'b1;
      tick();
      load = 1'b0;
      tick();
      tick();
      chk_out("pre_rst", 1'b1, 17'd30, 2'd2, 1'b0, 1'b1, 1'b0);
      #2 mr = 1'b0;
      #1;
      chk_out("async_rst", 1'b0, '0, 2'd0, 1'b0, 1'b0, 1'b0);
      tick();
      chk_out("rst_held", 1'b0, '0, 2'd0, 1'b0, 1'b0, 1'b0);
      mr = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk_out($sformatf("post_rst%0d", k), 1'b0, '0, 2'd0, 1'b0, 1'b0, 1'b0);
      end
      load = 1'b1;
      tick();
      load = 1'b0;
      chk_out("post_rst_load", 1'b1, 17'd10, 2'd0, 1'b0, 1'b1, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: sim time 100000 reached, want bench end earlier");
      $fatal(1, "timeout");
   end
endmodule
